// File: rtl/trng_pkg.sv
// trng_pkg: shared definitions for the TRNG entropy path.
//   - pair_state_t : von Neumann pair-collection state encoding
//   - TRNG_*_DEF   : default word width, sample divider and health-test limit
package trng_pkg;

  // Which half of a von Neumann pair the next sample fills.
  typedef enum logic {
    ST_FIRST  = 1'b0,
    ST_SECOND = 1'b1
  } pair_state_t;

  localparam int unsigned TRNG_WIDTH_DEF     = 8;
  localparam int unsigned TRNG_DIV_DEF       = 4;
  localparam int unsigned TRNG_RCT_LIMIT_DEF = 32;

endpackage : trng_pkg

// File: rtl/sync2.sv
// sync2: two-flop synchronizer for a single asynchronous bit.
// Ports:
//   clk : sampling clock
//   rst : asynchronous active-high reset, clears both stages to 0
//   d   : asynchronous input bit
//   q   : synchronized bit, two clk edges behind d
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic r_s1;

  // First stage may go metastable; second stage gives it a cycle to settle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= 1'b0;
      q    <= 1'b0;
    end else begin
      r_s1 <= d;
      q    <= r_s1;
    end
  end

endmodule : sync2

// File: rtl/trng_sampler.sv
// trng_sampler: consumer end of the TRNG path. Synchronizes and decimates the
// raw entropy bit, de-biases it with a von Neumann extractor, packs extracted
// bits into WIDTH-bit words and offers them on a valid/ready port. A
// repetition-count health test latches a sticky stuck flag.
// Ports:
//   clk       : clock
//   rst       : asynchronous active-high reset
//   en        : sampling enable
//   raw_in    : raw entropy bit, asynchronous to clk
//   out_data  : extracted word
//   out_valid : out_data holds an unconsumed word
//   out_ready : consumer accepts out_data this cycle
//   stuck     : sticky health-test failure
//   overrun   : sticky, a completed word was dropped
module trng_sampler
  import trng_pkg::*;
#(
  parameter int unsigned WIDTH     = TRNG_WIDTH_DEF,
  parameter int unsigned DIV       = TRNG_DIV_DEF,
  parameter int unsigned RCT_LIMIT = TRNG_RCT_LIMIT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             raw_in,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             stuck,
  output logic             overrun
);

  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned BIT_W = $clog2(WIDTH);
  localparam int unsigned RUN_W = $clog2(RCT_LIMIT + 1);

  // ---------------------------------------------------------------------------
  // Synchronizer
  // ---------------------------------------------------------------------------
  logic w_s2;

  sync2 u_sync2 (
    .clk (clk),
    .rst (rst),
    .d   (raw_in),
    .q   (w_s2)
  );

  // ---------------------------------------------------------------------------
  // Sample divider: one strobe every DIV enabled cycles, parked at 0 when idle
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] r_div_cnt;
  logic             w_strobe;

  assign w_strobe = en && (r_div_cnt == DIV_W'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_cnt <= '0;
    end else if (!en || w_strobe) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Von Neumann pair FSM
  // ---------------------------------------------------------------------------
  pair_state_t r_state;
  pair_state_t w_state_nxt;
  logic        r_a;
  logic        w_emit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_FIRST;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Unequal pairs emit their first sample; equal pairs are thrown away.
  always_comb begin
    w_state_nxt = r_state;
    w_emit      = 1'b0;
    if (!en) begin
      w_state_nxt = ST_FIRST;
    end else if (w_strobe) begin
      case (r_state)
        ST_FIRST: begin
          w_state_nxt = ST_SECOND;
        end
        ST_SECOND: begin
          w_emit      = (r_a != w_s2);
          w_state_nxt = ST_FIRST;
        end
        default: begin
          w_state_nxt = ST_FIRST;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a <= 1'b0;
    end else if (w_strobe && (r_state == ST_FIRST)) begin
      r_a <= w_s2;
    end
  end

  // ---------------------------------------------------------------------------
  // Packer: first extracted bit ends up in the MSB
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] r_shreg;
  logic [BIT_W-1:0] r_bit_cnt;
  logic [WIDTH-1:0] w_word;
  logic             w_word_done;

  assign w_word      = {r_shreg[WIDTH-2:0], r_a};
  assign w_word_done = w_emit && (r_bit_cnt == BIT_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shreg   <= '0;
      r_bit_cnt <= '0;
    end else if (w_emit) begin
      r_shreg   <= w_word;
      r_bit_cnt <= w_word_done ? '0 : (r_bit_cnt + BIT_W'(1));
    end
  end

  // ---------------------------------------------------------------------------
  // Repetition-count health test
  // ---------------------------------------------------------------------------
  logic [RUN_W-1:0] r_run;
  logic             r_prev;
  logic [RUN_W-1:0] w_run_nxt;
  logic             w_stuck_set;

  // A zero run count marks "no previous sample yet", so the first one counts 1.
  always_comb begin
    w_run_nxt = r_run;
    if ((r_run == RUN_W'(0)) || (w_s2 != r_prev)) begin
      w_run_nxt = RUN_W'(1);
    end else if (r_run != RUN_W'(RCT_LIMIT)) begin
      w_run_nxt = r_run + RUN_W'(1);
    end
  end

  assign w_stuck_set = w_strobe && (w_run_nxt == RUN_W'(RCT_LIMIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run  <= '0;
      r_prev <= 1'b0;
    end else if (w_strobe) begin
      r_run  <= w_run_nxt;
      r_prev <= w_s2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stuck <= 1'b0;
    end else if (w_stuck_set) begin
      stuck <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Output slot and handshake
  // ---------------------------------------------------------------------------
  logic w_xfer;

  assign w_xfer = out_valid && out_ready;

  // A stuck source kills the slot outright; a word racing the stuck flag is
  // silently discarded rather than counted as an overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (stuck || w_stuck_set) begin
      out_valid <= 1'b0;
    end else if (w_word_done) begin
      if (!out_valid || w_xfer) begin
        out_data  <= w_word;
        out_valid <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (w_xfer) begin
      out_valid <= 1'b0;
    end
  end

endmodule : trng_sampler

// File: tb/tb_trng_sampler.sv
// tb_trng_sampler: directed self-checking bench for trng_sampler
// (WIDTH=8, DIV=1, RCT_LIMIT=32).
module tb_trng_sampler;

  logic       clk;
  logic       rst;
  logic       en;
  logic       raw_in;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       stuck;
  logic       overrun;

  int n_tests;
  int n_fail;

  trng_sampler #(
    .WIDTH     (8),
    .DIV       (1),
    .RCT_LIMIT (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .raw_in    (raw_in),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .stuck     (stuck),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Feed n raw samples (bits[n-1] first). en rises two cycles after the first
  // raw bit so the first strobe sees it through the synchronizer. out_ready is
  // raised before edge rdy_at when rdy_at >= 0. Returns 1 time unit after the
  // edge that took the last sample, with en dropped.
  task automatic send(input logic [63:0] bits, input int n, input int rdy_at);
    for (int i = 0; i < n + 2; i++) begin
      @(negedge clk);
      raw_in = (i < n) ? bits[6'(n - 1 - i)] : bits[0];
      en     = (i >= 2);
      if (i == rdy_at) out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    en = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_tests++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got=%h exp=00", out_data); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    n_tests++; if (stuck !== 1'b0)     begin n_fail++; $display("FAIL reset_stuck got=%b exp=0", stuck); end
    n_tests++; if (overrun !== 1'b0)   begin n_fail++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // 10,01,00,10,11,10,01,01,10,01 -> 1,0,-,1,-,1,0,0,1,0 = B2
  task automatic test_basic_word();
    out_ready = 1'b1;
    send(64'b10_01_00_10_11_10_01_01_10_01, 20, -1);
    n_tests++; if (out_valid !== 1'b1)  begin n_fail++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
    n_tests++; if (out_data !== 8'hB2)  begin n_fail++; $display("FAIL basic_data got=%h exp=b2", out_data); end
    @(posedge clk); #1;
    n_tests++; if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL basic_valid_drop got=%b exp=0", out_valid); end
  endtask

  // A5 then 3C with no consumer: A5 held, 3C dropped.
  task automatic test_overrun();
    out_ready = 1'b0;
    send(64'b10_01_10_01_01_10_01_10_01_01_10_10_10_10_01_01, 32, -1);
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid got=%b exp=1", out_valid); end
    n_tests++; if (out_data !== 8'hA5) begin n_fail++; $display("FAIL ovr_data got=%h exp=a5", out_data); end
    n_tests++; if (overrun !== 1'b1)   begin n_fail++; $display("FAIL ovr_flag got=%b exp=1", overrun); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_drain got=%b exp=0", out_valid); end
    n_tests++; if (overrun !== 1'b1)   begin n_fail++; $display("FAIL ovr_sticky got=%b exp=1", overrun); end
  endtask

  // 5A held; C3 completes on the very edge 5A is accepted.
  task automatic test_back_to_back();
    pulse_reset();
    out_ready = 1'b0;
    send(64'b01_10_01_10_10_01_10_01, 16, -1);
    n_tests++; if (out_data !== 8'h5A) begin n_fail++; $display("FAIL b2b_first got=%h exp=5a", out_data); end
    send(64'b10_10_01_01_01_01_10_10, 16, 17);
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid got=%b exp=1", out_valid); end
    n_tests++; if (out_data !== 8'hC3) begin n_fail++; $display("FAIL b2b_data got=%h exp=c3", out_data); end
    n_tests++; if (overrun !== 1'b0)   begin n_fail++; $display("FAIL b2b_overrun got=%b exp=0", overrun); end
    @(posedge clk); #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
  endtask

  // Pending FF, then 31 ones (no trip), one more (trip), then good pairs.
  task automatic test_stuck();
    pulse_reset();
    out_ready = 1'b0;
    send(64'hAAAA, 16, -1);
    send({64{1'b1}}, 31, -1);
    n_tests++; if (stuck !== 1'b0)     begin n_fail++; $display("FAIL rct_31_stuck got=%b exp=0", stuck); end
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rct_31_valid got=%b exp=1", out_valid); end
    send(64'h1, 1, -1);
    n_tests++; if (stuck !== 1'b1)     begin n_fail++; $display("FAIL rct_32_stuck got=%b exp=1", stuck); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rct_32_valid got=%b exp=0", out_valid); end
    out_ready = 1'b1;
    send(64'hAAAA, 16, -1);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rct_after_valid got=%b exp=0", out_valid); end
    n_tests++; if (overrun !== 1'b0)   begin n_fail++; $display("FAIL rct_after_overrun got=%b exp=0", overrun); end
  endtask

  // One lone sample (0), en drop, then 10x8 must give FF.
  task automatic test_enable_gap();
    pulse_reset();
    out_ready = 1'b1;
    send(64'h0, 1, -1);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL en_half_valid got=%b exp=0", out_valid); end
    send(64'hAAAA, 16, -1);
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL en_valid got=%b exp=1", out_valid); end
    n_tests++; if (out_data !== 8'hFF) begin n_fail++; $display("FAIL en_data got=%h exp=ff", out_data); end
  endtask

  // Async reset mid-word with a held word and overrun set.
  task automatic test_async_reset();
    pulse_reset();
    out_ready = 1'b0;
    send(64'b10_01_10_01_01_10_01_10_01_01_10_10_10_10_01_01, 32, -1);
    send(64'b10_10_10, 6, -1);
    n_tests++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL arst_pre_overrun got=%b exp=1", overrun); end
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid got=%b exp=0", out_valid); end
    n_tests++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL arst_data got=%h exp=00", out_data); end
    n_tests++; if (overrun !== 1'b0)   begin n_fail++; $display("FAIL arst_overrun got=%b exp=0", overrun); end
    n_tests++; if (stuck !== 1'b0)     begin n_fail++; $display("FAIL arst_stuck got=%b exp=0", stuck); end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    send(64'h5555, 16, -1);
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL arst_post_valid got=%b exp=1", out_valid); end
    n_tests++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL arst_post_data got=%h exp=00", out_data); end
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b1;
    en        = 1'b0;
    raw_in    = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_basic_word();
    test_overrun();
    test_back_to_back();
    test_stuck();
    test_enable_gap();
    test_async_reset();
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_trng_sampler
